// File: rtl/riscv_pkg.sv
// Shared RV32I encodings: opcodes, immediate formats and decode helpers
// reused by ID, EX and the hazard logic.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src_imm;
        logic illegal;
    } ctrl_t;

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_t f;
        f = IMM_R;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = IMM_I;
            OPC_STORE:                      f = IMM_S;
            OPC_BRANCH:                     f = IMM_B;
            OPC_LUI, OPC_AUIPC:             f = IMM_U;
            OPC_JAL:                        f = IMM_J;
            default:                        f = IMM_R;
        endcase
        return f;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OPC_JAL) || (opcode == OPC_LUI) || (opcode == OPC_AUIPC));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

    // Unknown opcodes raise illegal with every other control bit low.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode, input logic [4:0] rd);
        ctrl_t c;
        c = '0;
        case (opcode)
            OPC_OP: c.reg_write = 1'b1;
            OPC_OP_IMM: begin
                c.reg_write   = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            OPC_LOAD: begin
                c.reg_write   = 1'b1;
                c.mem_read    = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                c.mem_write   = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: c.branch = 1'b1;
            OPC_JAL, OPC_JALR: begin
                c.reg_write   = 1'b1;
                c.jump        = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                c.reg_write   = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        if (rd == 5'd0) c.reg_write = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; each format is sign-extended
// from its top instruction bit to XLEN.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    import riscv_pkg::*;

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm32;

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm32 = '0;
        case (imm_fmt_of(instr[6:0]))
            IMM_I:   imm32 = 32'(imm_i);
            IMM_S:   imm32 = 32'(imm_s);
            IMM_B:   imm32 = 32'(imm_b);
            IMM_U:   imm32 = imm_u;
            IMM_J:   imm32 = 32'(imm_j);
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: RegFile read with write-back bypass, decode,
// load-use detection and the ID/EX pipeline register.
module id_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_id_valid,
    input  logic [31:0]     if_id_instr,
    input  logic [XLEN-1:0] if_id_pc,
    input  logic            flush,
    input  logic            ex_hold,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_write_en,
    input  logic [4:0]      wb_dest_addr,
    input  logic [XLEN-1:0] wb_write_data,
    output logic            stall_if,
    output logic            ex_valid,
    output logic            ex_illegal,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [4:0]      ex_rd_addr,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_alu_src_imm
);
    import riscv_pkg::*;

    // x0 is forced here because RegFile stores writes to it; a same-cycle
    // write-back is forwarded since RegFile only updates on the clock edge.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_en,
        input logic [4:0]      wb_addr,
        input logic [XLEN-1:0] wb_data
    );
        if (addr == 5'd0) return '0;
        if (wb_en && (wb_addr == addr)) return wb_data;
        return rf_data;
    endfunction

    // ---- ID (p0): decode of the instruction sitting in IF/ID ----
    logic [6:0]      opcode_p0;
    logic [4:0]      rs1_p0;
    logic [4:0]      rs2_p0;
    logic [4:0]      rd_p0;
    logic [XLEN-1:0] rs1_val_p0;
    logic [XLEN-1:0] rs2_val_p0;
    logic [XLEN-1:0] imm_p0;
    ctrl_t           ctrl_p0;
    logic            lu_p0;
    ctrl_t           ex_ctrl;

    assign opcode_p0 = if_id_instr[6:0];
    assign rd_p0     = if_id_instr[11:7];
    assign rs1_p0    = if_id_instr[19:15];
    assign rs2_p0    = if_id_instr[24:20];

    assign rf_rs1_addr = rs1_p0;
    assign rf_rs2_addr = rs2_p0;

    assign rs1_val_p0 = read_operand(rs1_p0, rf_rs1_data, wb_write_en, wb_dest_addr, wb_write_data);
    assign rs2_val_p0 = read_operand(rs2_p0, rf_rs2_data, wb_write_en, wb_dest_addr, wb_write_data);

    assign ctrl_p0 = decode_ctrl(opcode_p0, rd_p0);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_id_instr),
        .imm   (imm_p0)
    );

    assign lu_p0 = if_id_valid && ex_valid && ex_ctrl.mem_read && (ex_rd_addr != 5'd0) &&
                   ((uses_rs1(opcode_p0) && (rs1_p0 == ex_rd_addr)) ||
                    (uses_rs2(opcode_p0) && (rs2_p0 == ex_rd_addr)));

    // A redirect overrides any stall: the instruction in IF/ID is dead anyway.
    assign stall_if = reset_n && !flush && (ex_hold || lu_p0);

    // ---- ID/EX register (p1) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= RESET_PC;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (!ex_hold) begin
            if (lu_p0) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
            end else begin
                ex_valid <= if_id_valid;
                ex_ctrl  <= if_id_valid ? ctrl_p0 : '0;
            end
            ex_pc       <= if_id_pc;
            ex_rs1_data <= rs1_val_p0;
            ex_rs2_data <= rs2_val_p0;
            ex_imm      <= imm_p0;
            ex_rs1_addr <= rs1_p0;
            ex_rs2_addr <= rs2_p0;
            ex_rd_addr  <= rd_p0;
            ex_opcode   <= opcode_p0;
            ex_funct3   <= if_id_instr[14:12];
            ex_funct7b5 <= if_id_instr[30];
        end
    end

    assign ex_illegal     = ex_ctrl.illegal;
    assign ex_reg_write   = ex_ctrl.reg_write;
    assign ex_mem_read    = ex_ctrl.mem_read;
    assign ex_mem_write   = ex_ctrl.mem_write;
    assign ex_branch      = ex_ctrl.branch;
    assign ex_jump        = ex_ctrl.jump;
    assign ex_alu_src_imm = ex_ctrl.alu_src_imm;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus a randomized run
// against a behavioural model of the decode stage and its RegFile.
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    localparam logic [6:0] M_OP     = 7'h33;
    localparam logic [6:0] M_OPIMM  = 7'h13;
    localparam logic [6:0] M_LOAD   = 7'h03;
    localparam logic [6:0] M_STORE  = 7'h23;
    localparam logic [6:0] M_BRANCH = 7'h63;
    localparam logic [6:0] M_JAL    = 7'h6F;
    localparam logic [6:0] M_JALR   = 7'h67;
    localparam logic [6:0] M_LUI    = 7'h37;
    localparam logic [6:0] M_AUIPC  = 7'h17;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        flush;
    logic        ex_hold;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        wb_write_en;
    logic [4:0]  wb_dest_addr;
    logic [31:0] wb_write_data;
    logic        stall_if;
    logic        ex_valid, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src_imm;

    logic [31:0] rf [32];
    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .flush(flush), .ex_hold(ex_hold),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_write_en(wb_write_en), .wb_dest_addr(wb_dest_addr), .wb_write_data(wb_write_data),
        .stall_if(stall_if),
        .ex_valid(ex_valid), .ex_illegal(ex_illegal),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src_imm(ex_alu_src_imm)
    );

    typedef struct packed {
        logic        valid, illegal, reg_write, mem_read, mem_write, branch, jump, alu_src_imm;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
    } id_ex_t;

    id_ex_t exp_s;
    int     n_checks = 0;
    int     n_fail   = 0;
    logic   stall_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            M_OPIMM, M_LOAD, M_JALR: v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
            M_STORE:  v = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
            M_BRANCH: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                          int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            M_LUI, M_AUIPC: v = int'(ins & 32'hFFFF_F000);
            M_JAL:    v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 +
                          int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default:  v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] a, input logic we,
                                                  input logic [4:0] wd, input logic [31:0] wdat);
        if (a == 5'd0) return 32'd0;
        if (we && wd == a) return wdat;
        return rf[a];
    endfunction

    function automatic id_ex_t model_load(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                          input logic we, input logic [4:0] wd, input logic [31:0] wdat);
        id_ex_t     r;
        logic [6:0] o;
        logic       legal;
        r = '0;
        o = ins[6:0];
        legal = o inside {M_OP, M_OPIMM, M_LOAD, M_STORE, M_BRANCH, M_JAL, M_JALR, M_LUI, M_AUIPC};
        r.valid   = v;
        r.illegal = v && !legal;
        if (v && legal) begin
            r.reg_write   = (o != M_STORE) && (o != M_BRANCH) && (ins[11:7] != 5'd0);
            r.mem_read    = (o == M_LOAD);
            r.mem_write   = (o == M_STORE);
            r.branch      = (o == M_BRANCH);
            r.jump        = (o == M_JAL) || (o == M_JALR);
            r.alu_src_imm = (o != M_OP) && (o != M_BRANCH);
        end
        r.pc   = pc;
        r.imm  = model_imm(ins);
        r.rs1a = ins[19:15];
        r.rs2a = ins[24:20];
        r.rda  = ins[11:7];
        r.rs1d = model_operand(ins[19:15], we, wd, wdat);
        r.rs2d = model_operand(ins[24:20], we, wd, wdat);
        r.opc  = o;
        r.f3   = ins[14:12];
        r.f7b5 = ins[30];
        return r;
    endfunction

    function automatic logic model_lu(input logic v, input logic [31:0] ins);
        logic u1, u2;
        u1 = !(ins[6:0] inside {M_JAL, M_LUI, M_AUIPC});
        u2 = ins[6:0] inside {M_OP, M_STORE, M_BRANCH};
        return v && exp_s.valid && exp_s.mem_read && (exp_s.rda != 5'd0) &&
               ((u1 && ins[19:15] == exp_s.rda) || (u2 && ins[24:20] == exp_s.rda));
    endfunction

    function automatic id_ex_t bubble(input id_ex_t x);
        id_ex_t r;
        r = x;
        {r.valid, r.illegal, r.reg_write, r.mem_read, r.mem_write, r.branch, r.jump, r.alu_src_imm} = '0;
        return r;
    endfunction

    function automatic id_ex_t reset_state();
        id_ex_t r;
        r = '0;
        r.pc = RST_PC;
        return r;
    endfunction

    task automatic compare_state();
        chk("ex_valid", 32'(ex_valid), 32'(exp_s.valid));
        chk("ex_ctrl",
            32'({ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src_imm}),
            32'({exp_s.illegal, exp_s.reg_write, exp_s.mem_read, exp_s.mem_write, exp_s.branch,
                 exp_s.jump, exp_s.alu_src_imm}));
        if (exp_s.valid) begin
            chk("ex_pc", ex_pc, exp_s.pc);
            chk("ex_rs1_data", ex_rs1_data, exp_s.rs1d);
            chk("ex_rs2_data", ex_rs2_data, exp_s.rs2d);
            chk("ex_imm", ex_imm, exp_s.imm);
            chk("ex_regs", 32'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr}),
                32'({exp_s.rs1a, exp_s.rs2a, exp_s.rda}));
            chk("ex_fields", 32'({ex_opcode, ex_funct3, ex_funct7b5}),
                32'({exp_s.opc, exp_s.f3, exp_s.f7b5}));
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and checks the result at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ho,
                         input logic we, input logic [4:0] wd, input logic [31:0] wdat);
        logic   exp_stall;
        id_ex_t nxt;
        if_id_valid = v; if_id_instr = ins; if_id_pc = pc;
        flush = fl; ex_hold = ho;
        wb_write_en = we; wb_dest_addr = wd; wb_write_data = wdat;
        #1;
        exp_stall  = !fl && (ho || model_lu(v, ins));
        stall_seen = stall_if;
        chk("stall_if", 32'(stall_seen), 32'(exp_stall));
        chk("rf_addr", 32'({rf_rs1_addr, rf_rs2_addr}), 32'({ins[19:15], ins[24:20]}));
        if (fl) nxt = bubble(exp_s);
        else if (ho) nxt = exp_s;
        else if (model_lu(v, ins)) nxt = bubble(model_load(v, ins, pc, we, wd, wdat));
        else nxt = model_load(v, ins, pc, we, wd, wdat);
        @(posedge clk);
        #1;
        if (we) rf[wd] = wdat;
        exp_s = nxt;
        @(negedge clk);
        compare_state();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opcs [12];
        opcs = '{M_OP, M_OPIMM, M_LOAD, M_STORE, M_BRANCH, M_JAL, M_JALR, M_LUI, M_AUIPC,
                 M_LOAD, 7'h7F, 7'h73};
        ins = $urandom;
        ins[6:0]   = opcs[$urandom_range(0, 11)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cur;
        logic        prev_stall;
        logic        rv, rf_l, rh, rwe;
        reset_n = 1'b0;
        if_id_valid = 1'b0; if_id_instr = '0; if_id_pc = '0;
        flush = 1'b0; ex_hold = 1'b1;
        wb_write_en = 1'b0; wb_dest_addr = '0; wb_write_data = '0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rf[5] = 32'd124;
        exp_s = reset_state();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, RST_PC);
        chk("rst_data", ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
        chk("rst_rd", 32'(ex_rd_addr), 32'd0);
        chk("rst_stall", 32'(stall_if), 32'd0);
        reset_n = 1'b1;
        ex_hold = 1'b0;

        // addi x6,x5,-3
        cycle(1'b1, 32'hFFD28313, 32'h40, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("addi_rs1", ex_rs1_data, 32'd124);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFD);
        chk("addi_rd", 32'(ex_rd_addr), 32'd6);
        chk("addi_rw_alu", 32'({ex_reg_write, ex_alu_src_imm}), 32'b11);

        // asynchronous reset while ID/EX holds a valid instruction
        #2;
        reset_n = 1'b0;
        ex_hold = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_pc", ex_pc, RST_PC);
        chk("async_rst_stall", 32'(stall_if), 32'd0);
        exp_s = reset_state();
        @(negedge clk);
        reset_n = 1'b1;
        ex_hold = 1'b0;

        // write-back bypass: add x7,x10,x10
        rf[10] = 32'd50;
        cycle(1'b1, 32'h00A503B3, 32'h44, 1'b0, 1'b0, 1'b1, 5'd10, 32'd214);
        chk("byp_rs1", ex_rs1_data, 32'd214);
        chk("byp_rs2", ex_rs2_data, 32'd214);
        rf[10] = 32'd77;
        cycle(1'b1, 32'h00A503B3, 32'h48, 1'b0, 1'b0, 1'b1, 5'd0, 32'd99);
        chk("nobyp_x0_rs1", ex_rs1_data, 32'd77);
        // add x7,x0,x0 with RegFile x0 holding 99 and a write to x0 in flight
        cycle(1'b1, 32'h000003B3, 32'h4C, 1'b0, 1'b0, 1'b1, 5'd0, 32'd55);
        chk("x0_read", ex_rs1_data | ex_rs2_data, 32'd0);

        // load-use: lw x5,0(x1) ; add x7,x5,x2
        cycle(1'b1, 32'h0000A283, 32'h50, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h002283B3, 32'h54, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_stall", 32'(stall_seen), 32'd1);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        cycle(1'b1, 32'h002283B3, 32'h54, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_release", 32'(stall_seen), 32'd0);
        chk("lu_issue", 32'({ex_valid, ex_rs1_addr}), 32'({1'b1, 5'd5}));
        // independent follower: add x7,x2,x3
        cycle(1'b1, 32'h0000A283, 32'h58, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h003103B3, 32'h5C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("nolu_stall", 32'(stall_seen), 32'd0);
        chk("nolu_valid", 32'(ex_valid), 32'd1);

        // flush together with a load-use hazard
        cycle(1'b1, 32'h0000A283, 32'h60, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h002283B3, 32'h64, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("flush_lu_stall", 32'(stall_seen), 32'd0);
        chk("flush_lu_valid", 32'(ex_valid), 32'd0);

        // hold for three cycles
        cycle(1'b1, 32'hFFD28313, 32'h68, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rand_instr(), 32'h6C, 1'b0, 1'b1, 1'b1, 5'd3, $urandom);
            chk("hold_stall", 32'(stall_seen), 32'd1);
            chk("hold_imm", ex_imm, 32'hFFFF_FFFD);
            chk("hold_pc_rd", ex_pc ^ 32'(ex_rd_addr), 32'h68 ^ 32'd6);
        end

        // immediates and illegal opcode
        cycle(1'b1, 32'hFE000CE3, 32'h70, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
        chk("beq_ctrl", 32'({ex_branch, ex_reg_write}), 32'b10);
        cycle(1'b1, 32'h001000EF, 32'h74, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("jal_imm", ex_imm, 32'h0000_0800);
        chk("jal_ctrl", 32'({ex_jump, ex_reg_write, ex_rd_addr}), 32'({2'b11, 5'd1}));
        cycle(1'b1, 32'h00A5037F, 32'h78, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("illegal_flag", 32'({ex_valid, ex_illegal}), 32'b11);
        chk("illegal_ctrl",
            32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src_imm}), 32'd0);

        // randomized run; IF holds its instruction while stalled
        prev_stall = 1'b0;
        cur = rand_instr();
        for (int n = 0; n < 600; n++) begin
            if (!prev_stall) cur = rand_instr();
            rv   = ($urandom_range(0, 9) != 0);
            rf_l = ($urandom_range(0, 11) == 0);
            rh   = ($urandom_range(0, 7) == 0);
            rwe  = 1'($urandom_range(0, 1));
            cycle(rv, cur, 32'h1000 + 32'(n) * 4, rf_l, rh, rwe, 5'($urandom_range(0, 7)), $urandom);
            prev_stall = stall_seen;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline; sits between the IF/ID register and EX, directly upstream of and wrapped around RegFile.
- Drives RegFile rs1/rs2 read addresses and consumes the returned read data.
- Adds write-back bypass, because RegFile writes on posedge and a same-cycle write is not yet visible to its combinational read.
- Generates immediates and control, detects load-use hazards, and owns the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, value of ex_pc after reset

Ports:
clk  in  1  clock, all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  32  instruction word
if_id_pc  in  XLEN  instruction PC
flush  in  1  branch/jump redirect from EX; kill the instruction entering ID/EX
ex_hold  in  1  downstream cannot accept; freeze ID/EX
rf_rs1_addr  out  5  RegFile read address 1 (instr[19:15])
rf_rs2_addr  out  5  RegFile read address 2 (instr[24:20])
rf_rs1_data  in  XLEN  RegFile read data 1
rf_rs2_data  in  XLEN  RegFile read data 2
wb_write_en  in  1  write-back valid, same signal driven to RegFile
wb_dest_addr  in  5  write-back destination
wb_write_data  in  XLEN  write-back data
stall_if  out  1  hold PC and IF/ID this cycle
ex_valid, ex_illegal  out  1 each  ID/EX valid; unknown opcode
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  ID/EX datapath
ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each  ID/EX register indices, for EX forwarding
ex_opcode  out  7  ID/EX opcode
ex_funct3  out  3  ID/EX funct3
ex_funct7b5  out  1  ID/EX instr[30]
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src_imm  out  1 each  ID/EX control

Behaviour:
- Reset (async, reset_n=0):
  - ex_valid=0; all ex_* control = 0; ex_* data and address fields = 0; ex_pc=RESET_PC.
  - stall_if is combinational and reads 0 while in reset.
- Operand read (combinational):
  - rf_rs*_addr come straight from if_id_instr.
  - The operand is 0 if its addr==0. RegFile does not protect x0, so ID must.
  - Otherwise the operand is wb_write_data if wb_write_en && wb_dest_addr==addr && addr!=0.
  - Otherwise the operand is rf_rs*_data.
- Decode:
  - Supported opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - uses_rs1: all except JAL, LUI, AUIPC. uses_rs2: OP, STORE, BRANCH.
  - reg_write=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC, forced 0 when rd==0.
  - Any other opcode: ex_illegal=1 and all control 0; still passes as valid for the trap unit.
- Immediates (sign-extended to XLEN):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: 0
- Load-use: lu = if_id_valid && ex_valid && ex_mem_read && ex_rd_addr!=0 && ((uses_rs1 && rs1==ex_rd_addr) || (uses_rs2 && rs2==ex_rd_addr)).
- Next-state priority each posedge:
  - flush: ex_valid<=0; control fields <=0.
  - else ex_hold: all ID/EX fields keep their value.
  - else lu: bubble, i.e. ex_valid<=0 and control <=0; data fields don't-care.
  - else: load the decoded instruction; ex_valid<=if_id_valid; control is gated by if_id_valid.
- stall_if = !flush && (ex_hold || lu).
- Latency: one cycle from IF/ID to ID/EX. A load followed by a dependent instruction costs exactly one bubble.
- Reset asserted mid-operation clears ID/EX immediately, including an in-progress bubble.

Decomposition:
- Shared package riscv_pkg: opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC) and immediate-format encodings (IMM_I/S/B/U/J). EX and the hazard logic reuse them.
- Sub-module imm_gen: purely combinational, input instr[31:0], output imm[XLEN-1:0].

Test Plan:
1. Reset with reset_n=0 mid-cycle while ex_valid=1 -> ex_valid=0 at once with no clock edge; ex_pc=0; stall_if=0.
2. RF x5=124, addi x6,x5,-3 (0xFFD28313) -> next cycle ex_rs1_data=124, ex_imm=0xFFFFFFFD, ex_rd_addr=6, ex_reg_write=1, ex_alu_src_imm=1.
3. WB bypass: wb_write_en=1, dest=10, data=214 in the same cycle as add x7,x10,x10 -> ex_rs1_data=ex_rs2_data=214. Repeat with dest=0 and data=99 -> operand from RF; a rs=x0 read gives 0.
4. Load-use: lw x5,0(x1) then add x7,x5,x2 -> stall_if=1 for exactly one cycle and one ex_valid=0 bubble. Same pair with add x7,x2,x3 -> no stall.
5. Flush and load-use in the same cycle -> ex_valid=0, stall_if=0. ex_hold=1 for 3 cycles -> ID/EX fields constant and stall_if=1 throughout.
6. Immediates: beq offset -8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8. jal x1,+2048 (0x001000EF) -> ex_imm=0x800. opcode 0x7F -> ex_illegal=1 and all control 0.
